// File: rtl/sad_pkg.sv
// ============================================================================
// Module      : sad_pkg
// Description : Shared defaults, constants and state encoding for the SAD
//               block-match search sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sad_pkg;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_BUF_SIZE = 80;
    localparam int DEF_CNT_W    = 7;
    localparam int DEF_NUM_CAND = 16;
    localparam int DEF_CAND_W   = 4;
    localparam int DEF_SAD_W    = 15;

    localparam logic [DEF_SAD_W-1:0] SAD_MAX = '1;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_CLR_ALL   = 4'd1,
        S_LOAD_TPL  = 4'd2,
        S_LOAD_CAND = 4'd3,
        S_FIRE      = 4'd4,
        S_WAIT      = 4'd5,
        S_UPDATE    = 4'd6,
        S_CLR_CAND  = 4'd7,
        S_DONE      = 4'd8
    } state_t;

endpackage

`default_nettype wire

// File: rtl/sad_min_tracker.sv
// ============================================================================
// Module      : sad_min_tracker
// Description : Holds the running minimum SAD and the candidate index that
//               produced it; clear restores the all-ones sentinel.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sad_min_tracker #(
    parameter int SAD_W  = 15,
    parameter int CAND_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              upd,
    input  logic [SAD_W-1:0]  sad_in,
    input  logic [CAND_W-1:0] idx_in,
    output logic [SAD_W-1:0]  best_sad,
    output logic [CAND_W-1:0] best_idx
);

    // Strict less-than: on a tie the earlier (lower) index is kept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            best_sad <= '1;
            best_idx <= '0;
        end else if (clr) begin
            best_sad <= '1;
            best_idx <= '0;
        end else if (upd && (sad_in < best_sad)) begin
            best_sad <= sad_in;
            best_idx <= idx_in;
        end
    end

endmodule

`default_nettype wire

// File: rtl/sad_search_sequencer.sv
// ============================================================================
// Module      : sad_search_sequencer
// Description : Streams a template and NUM_CAND candidate blocks into the
//               pixel buffers, fires the SAD core per candidate, tracks min.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sad_search_sequencer
    import sad_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int BUF_SIZE = DEF_BUF_SIZE,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int NUM_CAND = DEF_NUM_CAND,
    parameter int CAND_W   = DEF_CAND_W,
    parameter int SAD_W    = DEF_SAD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              pix_valid,
    input  logic [WIDTH-1:0]  pix_data,
    output logic              pix_ready,
    output logic [WIDTH-1:0]  buf_data,
    output logic              tpl_wr_en,
    output logic              cand_wr_en,
    output logic              tpl_clr,
    output logic              cand_clr,
    input  logic              tpl_full,
    input  logic              cand_full,
    output logic              sad_start,
    input  logic              sad_done,
    input  logic [SAD_W-1:0]  sad_value,
    output logic [SAD_W-1:0]  best_sad,
    output logic [CAND_W-1:0] best_idx,
    output logic              busy,
    output logic              done
);

    localparam logic [CNT_W-1:0]  c_last_byte = CNT_W'(BUF_SIZE - 1);
    localparam logic [CAND_W-1:0] c_last_cand = CAND_W'(NUM_CAND - 1);

    state_t              r_state;
    state_t              w_next;
    logic [CNT_W-1:0]    r_byte_cnt;
    logic [CAND_W-1:0]   r_cand_idx;
    logic [SAD_W-1:0]    r_sad_cap;
    logic                w_accept;
    logic                w_last_byte;
    logic                w_clr_best;
    logic                w_upd_best;

    assign buf_data    = pix_data;
    assign busy        = (r_state != S_IDLE);
    assign w_accept    = pix_valid & pix_ready;
    assign w_last_byte = (r_byte_cnt == c_last_byte);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Load states use pix_valid directly so pix_ready never feeds back into itself.
    always_comb begin
        w_next     = r_state;
        pix_ready  = 1'b0;
        tpl_wr_en  = 1'b0;
        cand_wr_en = 1'b0;
        tpl_clr    = 1'b0;
        cand_clr   = 1'b0;
        sad_start  = 1'b0;
        done       = 1'b0;
        w_clr_best = 1'b0;
        w_upd_best = 1'b0;
        case (r_state)
            S_IDLE:      if (start) w_next = S_CLR_ALL;
            S_CLR_ALL: begin
                tpl_clr    = 1'b1;
                cand_clr   = 1'b1;
                w_clr_best = 1'b1;
                w_next     = S_LOAD_TPL;
            end
            S_LOAD_TPL: begin
                pix_ready = 1'b1;
                tpl_wr_en = pix_valid;
                if (pix_valid && w_last_byte) w_next = S_LOAD_CAND;
            end
            S_LOAD_CAND: begin
                pix_ready  = 1'b1;
                cand_wr_en = pix_valid;
                if (pix_valid && w_last_byte) w_next = S_FIRE;
            end
            S_FIRE: begin
                if (tpl_full && cand_full) begin
                    sad_start = 1'b1;
                    w_next    = S_WAIT;
                end
            end
            S_WAIT:      if (sad_done) w_next = S_UPDATE;
            S_UPDATE: begin
                w_upd_best = 1'b1;
                w_next     = (r_cand_idx == c_last_cand) ? S_DONE : S_CLR_CAND;
            end
            S_CLR_CAND: begin
                cand_clr = 1'b1;
                w_next   = S_LOAD_CAND;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default:     w_next = S_IDLE;
        endcase
    end

    // Counter is held at zero outside the load states, so every load starts fresh.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             r_byte_cnt <= '0;
        else if (!pix_ready) r_byte_cnt <= '0;
        else if (w_accept)   r_byte_cnt <= w_last_byte ? '0 : r_byte_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                     r_cand_idx <= '0;
        else if (w_clr_best)                         r_cand_idx <= '0;
        else if (w_upd_best && (r_cand_idx != c_last_cand)) r_cand_idx <= r_cand_idx + CAND_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                   r_sad_cap <= '0;
        else if ((r_state == S_WAIT) && sad_done)  r_sad_cap <= sad_value;
    end

    sad_min_tracker #(
        .SAD_W  (SAD_W),
        .CAND_W (CAND_W)
    ) u_min_tracker (
        .clk      (clk),
        .rst      (rst),
        .clr      (w_clr_best),
        .upd      (w_upd_best),
        .sad_in   (r_sad_cap),
        .idx_in   (r_cand_idx),
        .best_sad (best_sad),
        .best_idx (best_idx)
    );

endmodule

`default_nettype wire

// File: tb/tb_sad_search_sequencer.sv
// ============================================================================
// Module      : tb_sad_search_sequencer
// Description : Randomized bench with buffer/SAD-core models and a reference
//               min-SAD model for sad_search_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_sad_search_sequencer;

    localparam int WIDTH      = 8;
    localparam int BUF_SIZE   = 80;
    localparam int CNT_W      = 7;
    localparam int NUM_CAND   = 16;
    localparam int CAND_W     = 4;
    localparam int SAD_W      = 15;
    localparam int STREAM_LEN = BUF_SIZE * (NUM_CAND + 1);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              pix_valid;
    logic [WIDTH-1:0]  pix_data;
    logic              pix_ready;
    logic [WIDTH-1:0]  buf_data;
    logic              tpl_wr_en, cand_wr_en, tpl_clr, cand_clr;
    logic              tpl_full, cand_full;
    logic              sad_start, sad_done;
    logic [SAD_W-1:0]  sad_value;
    logic [SAD_W-1:0]  best_sad;
    logic [CAND_W-1:0] best_idx;
    logic              busy, done;

    always #5 clk = ~clk;

    sad_search_sequencer #(
        .WIDTH(WIDTH), .BUF_SIZE(BUF_SIZE), .CNT_W(CNT_W),
        .NUM_CAND(NUM_CAND), .CAND_W(CAND_W), .SAD_W(SAD_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
        .buf_data(buf_data), .tpl_wr_en(tpl_wr_en), .cand_wr_en(cand_wr_en),
        .tpl_clr(tpl_clr), .cand_clr(cand_clr),
        .tpl_full(tpl_full), .cand_full(cand_full),
        .sad_start(sad_start), .sad_done(sad_done), .sad_value(sad_value),
        .best_sad(best_sad), .best_idx(best_idx), .busy(busy), .done(done)
    );

    // Scenario pixels
    logic [WIDTH-1:0] tpl_pix  [BUF_SIZE];
    logic [WIDTH-1:0] cand_pix [NUM_CAND][BUF_SIZE];

    function automatic logic [WIDTH-1:0] get_byte(input int i);
        if (i < BUF_SIZE) return tpl_pix[i];
        return cand_pix[(i - BUF_SIZE) / BUF_SIZE][(i - BUF_SIZE) % BUF_SIZE];
    endfunction

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: SAD of each candidate against the template, first minimum wins.
    task automatic model(output int e_sad, output int e_idx);
        e_sad = 0;
        e_idx = 0;
        for (int k = 0; k < NUM_CAND; k++) begin
            int s;
            s = 0;
            for (int i = 0; i < BUF_SIZE; i++) begin
                int d;
                d = int'(cand_pix[k][i]) - int'(tpl_pix[i]);
                s += (d < 0) ? -d : d;
            end
            if (k == 0 || s < e_sad) begin
                e_sad = s;
                e_idx = k;
            end
        end
    endtask

    // Byte source: restarts its stream whenever src_epoch changes.
    int src_epoch = 0;
    int src_pct   = 100;

    initial begin : src_proc
        int  idx;
        int  seen;
        bit  acc;
        idx = 0;
        seen = 0;
        pix_valid = 1'b0;
        pix_data  = '0;
        forever begin
            @(negedge clk);
            acc = pix_valid && pix_ready;
            @(posedge clk);
            #1;
            if (seen != src_epoch) begin
                seen = src_epoch;
                idx  = 0;
            end else if (acc) begin
                idx++;
            end
            pix_valid = (idx < STREAM_LEN) && (int'($urandom_range(99)) < src_pct);
            pix_data  = (idx < STREAM_LEN) ? get_byte(idx) : WIDTH'($urandom_range(255));
        end
    end

    // Buffer models: cleared only by their clr strobes, never by rst.
    logic [WIDTH-1:0] tmem [BUF_SIZE];
    logic [WIDTH-1:0] cmem [BUF_SIZE];
    int tcnt = 0;
    int ccnt = 0;

    assign tpl_full  = (tcnt == BUF_SIZE);
    assign cand_full = (ccnt == BUF_SIZE);

    always @(posedge clk) begin
        if (tpl_clr) tcnt <= 0;
        else if (tpl_wr_en && tcnt < BUF_SIZE) begin
            tmem[tcnt] <= buf_data;
            tcnt <= tcnt + 1;
        end
        if (cand_clr) ccnt <= 0;
        else if (cand_wr_en && ccnt < BUF_SIZE) begin
            cmem[ccnt] <= buf_data;
            ccnt <= ccnt + 1;
        end
    end

    function automatic logic [SAD_W-1:0] buf_sad();
        int s;
        s = 0;
        for (int i = 0; i < BUF_SIZE; i++) begin
            int d;
            d = int'(cmem[i]) - int'(tmem[i]);
            s += (d < 0) ? -d : d;
        end
        return SAD_W'(s);
    endfunction

    // SAD core model with programmable latency
    int               core_lat = 3;
    int               core_cnt = 0;
    bit               core_busy = 1'b0;
    logic             core_done = 1'b0;
    logic [SAD_W-1:0] core_val = '0;
    logic             inj_done = 1'b0;

    assign sad_done  = core_done | inj_done;
    assign sad_value = core_val;

    always @(posedge clk) begin
        core_done <= 1'b0;
        if (sad_start) begin
            core_busy <= 1'b1;
            core_cnt  <= core_lat;
            core_val  <= buf_sad();
        end else if (core_busy) begin
            if (core_cnt == 0) begin
                core_done <= 1'b1;
                core_busy <= 1'b0;
            end else begin
                core_cnt <= core_cnt - 1;
            end
        end
    end

    // Event counters sampled mid-cycle
    int n_tpl_wr = 0, n_cand_wr = 0, n_sad_start = 0, n_done = 0, n_tpl_clr = 0, n_cand_clr = 0;

    always @(negedge clk) begin
        if (tpl_wr_en)  n_tpl_wr    <= n_tpl_wr + 1;
        if (cand_wr_en) n_cand_wr   <= n_cand_wr + 1;
        if (sad_start)  n_sad_start <= n_sad_start + 1;
        if (done)       n_done      <= n_done + 1;
        if (tpl_clr)    n_tpl_clr   <= n_tpl_clr + 1;
        if (cand_clr)   n_cand_clr  <= n_cand_clr + 1;
    end

    // mode 0: plain, 1: spurious start/sad_done, 2: async reset at byte 40 of candidate 2
    task automatic run_search(input string name, input int pct, input int mode);
        int e_sad, e_idx, cyc;
        int b_tw, b_cw, b_ss, b_dn, b_tc, b_cc;
        bit got, hit_start, hit_done, pend;
        model(e_sad, e_idx);
        src_pct  = pct;
        src_epoch++;
        core_lat = int'($urandom_range(6));
        repeat (2) @(posedge clk);
        #1;
        b_tw = n_tpl_wr; b_cw = n_cand_wr; b_ss = n_sad_start;
        b_dn = n_done;   b_tc = n_tpl_clr; b_cc = n_cand_clr;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({name, "/busy_after_start"}, 32'(busy), 32'd1);
        got = 0; cyc = 0; hit_start = 0; hit_done = 0; pend = 0;
        while (!got && cyc < 20000) begin
            @(posedge clk);
            #1;
            cyc++;
            start    = 1'b0;
            inj_done = 1'b0;
            if (pend) begin
                check({name, "/spurious_ready"}, 32'(pix_ready), 32'd1);
                pend = 0;
            end
            if (done) begin
                got = 1;
                check({name, "/best_sad"}, 32'(best_sad), 32'(e_sad));
                check({name, "/best_idx"}, 32'(best_idx), 32'(e_idx));
            end else if (mode == 1 && !hit_done && (n_tpl_wr - b_tw) >= 20) begin
                inj_done = 1'b1;
                hit_done = 1;
                pend     = 1;
            end else if (mode == 1 && !hit_start && (n_cand_wr - b_cw) >= 100) begin
                start     = 1'b1;
                hit_start = 1;
                pend      = 1;
            end else if (mode == 2 && (n_cand_wr - b_cw) >= 2 * BUF_SIZE + 40) begin
                #2;
                rst = 1'b1;
                #1;
                check({name, "/rst_busy"},      32'(busy),       32'd0);
                check({name, "/rst_best_sad"},  32'(best_sad),   32'h7FFF);
                check({name, "/rst_best_idx"},  32'(best_idx),   32'd0);
                check({name, "/rst_pix_ready"}, 32'(pix_ready),  32'd0);
                check({name, "/rst_cand_wr"},   32'(cand_wr_en), 32'd0);
                repeat (3) @(posedge clk);
                #1;
                rst = 1'b0;
                return;
            end
        end
        check({name, "/done_seen"}, 32'(got), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check({name, "/idle"},        32'(busy),                 32'd0);
        check({name, "/hold_sad"},    32'(best_sad),             32'(e_sad));
        check({name, "/done_cnt"},    32'(n_done - b_dn),        32'd1);
        check({name, "/sad_starts"},  32'(n_sad_start - b_ss),   32'(NUM_CAND));
        check({name, "/tpl_wr"},      32'(n_tpl_wr - b_tw),      32'(BUF_SIZE));
        check({name, "/cand_wr"},     32'(n_cand_wr - b_cw),     32'(BUF_SIZE * NUM_CAND));
        check({name, "/tpl_clr"},     32'(n_tpl_clr - b_tc),     32'd1);
        check({name, "/cand_clr"},    32'(n_cand_clr - b_cc),    32'(NUM_CAND));
    endtask

    task automatic fill_random();
        for (int i = 0; i < BUF_SIZE; i++) tpl_pix[i] = WIDTH'($urandom_range(255));
        for (int k = 0; k < NUM_CAND; k++)
            for (int i = 0; i < BUF_SIZE; i++) cand_pix[k][i] = WIDTH'($urandom_range(255));
    endtask

    task automatic fill_directed();
        for (int i = 0; i < BUF_SIZE; i++) tpl_pix[i] = 8'h0A;
        for (int k = 0; k < NUM_CAND; k++)
            for (int i = 0; i < BUF_SIZE; i++)
                cand_pix[k][i] = (k == 5) ? 8'h0A : WIDTH'(8'h0B + k);
    endtask

    initial begin
        // Reset state, with pix_valid high to show no write enables leak out.
        repeat (4) @(posedge clk);
        #1;
        check("reset/busy",       32'(busy),       32'd0);
        check("reset/done",       32'(done),       32'd0);
        check("reset/pix_ready",  32'(pix_ready),  32'd0);
        check("reset/tpl_wr_en",  32'(tpl_wr_en),  32'd0);
        check("reset/cand_wr_en", 32'(cand_wr_en), 32'd0);
        check("reset/clr",        32'({tpl_clr, cand_clr}), 32'd0);
        check("reset/sad_start",  32'(sad_start),  32'd0);
        check("reset/best_sad",   32'(best_sad),   32'h7FFF);
        check("reset/best_idx",   32'(best_idx),   32'd0);
        check("reset/buf_data",   32'(buf_data),   32'(pix_data));
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("idle/wr_en_with_valid", 32'({tpl_wr_en, cand_wr_en}), 32'd0);

        fill_directed();
        run_search("full", 100, 0);

        for (int i = 0; i < BUF_SIZE; i++) tpl_pix[i] = 8'h0A;
        for (int k = 0; k < NUM_CAND; k++)
            for (int i = 0; i < BUF_SIZE; i++)
                cand_pix[k][i] = (k == 3 || k == 9) ? 8'h0B : WIDTH'(8'h0C + k);
        run_search("ties", 70, 0);

        fill_directed();
        run_search("backpressure", 50, 0);

        fill_random();
        run_search("spurious", 80, 1);

        fill_random();
        run_search("abort", 90, 2);
        repeat (2) @(posedge clk);
        run_search("restart", 90, 0);

        for (int r = 0; r < 2; r++) begin
            fill_random();
            run_search("random", 40 + 30 * r, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
